// File: rtl/mac_learn_age_table_if.sv
// Learn / lookup / status bundle between the frame parser, the MAC table and the fabric arbiter.
// The master side drives requests; the slave side (the table) returns results and status.
interface mac_learn_age_table_if #(
  parameter int pPORT_NUM = 8,
  parameter int pADDR_W   = 10
);
  localparam int PW = (pPORT_NUM > 1) ? $clog2(pPORT_NUM) : 1;

  logic               i_learn_valid;
  logic [pADDR_W-1:0] i_learn_index;
  logic [PW-1:0]      i_learn_port;
  logic               i_lookup_valid;
  logic [pADDR_W-1:0] i_lookup_index;
  logic               o_lookup_valid;
  logic               o_lookup_hit;
  logic [PW-1:0]      o_lookup_port;
  logic               o_flood;
  logic               o_port_move;
  logic [pADDR_W:0]   o_entry_count;
  logic               o_sweep_busy;
  logic               o_tick_overrun;

  modport master (
    output i_learn_valid, i_learn_index, i_learn_port, i_lookup_valid, i_lookup_index,
    input  o_lookup_valid, o_lookup_hit, o_lookup_port, o_flood, o_port_move,
           o_entry_count, o_sweep_busy, o_tick_overrun
  );

  modport slave (
    input  i_learn_valid, i_learn_index, i_learn_port, i_lookup_valid, i_lookup_index,
    output o_lookup_valid, o_lookup_hit, o_lookup_port, o_flood, o_port_move,
           o_entry_count, o_sweep_busy, o_tick_overrun
  );
endinterface

// File: rtl/mac_learn_age_table.sv
// MAC forwarding table: index-to-port binding with valid bits, per-entry age and a
// background aging sweep that retires entries whose age runs out.
module mac_learn_age_table #(
  parameter int pPORT_NUM = 8,
  parameter int pADDR_W   = 10,
  parameter int pAGE_W    = 9,
  parameter int pAGE_INIT = 300,
  parameter int pTICK_DIV = 32768
) (
  input  logic                 iclk,
  input  logic                 irst_n,
  mac_learn_age_table_if.slave bus
);
  localparam int PW = (pPORT_NUM > 1) ? $clog2(pPORT_NUM) : 1;
  localparam int D  = 2 ** pADDR_W;
  localparam int TW = (pTICK_DIV > 1) ? $clog2(pTICK_DIV) : 1;

  localparam logic [PW:0]         PORT_LIM  = (PW+1)'(pPORT_NUM);
  localparam logic [pAGE_W-1:0]   AGE_LOAD  = pAGE_W'(pAGE_INIT);
  localparam logic [pAGE_W-1:0]   AGE_ONE   = pAGE_W'(1);
  localparam logic [TW-1:0]       TICK_LAST = TW'(pTICK_DIV - 1);
  localparam logic [pADDR_W-1:0]  PTR_LAST  = '1;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [pADDR_W-1:0] ptr_q, ptr_d;
  logic               pend_q, pend_d;
  logic               ovr_q, ovr_d;
  logic [TW-1:0]      presc_q;
  logic               tick;

  logic [D-1:0]       valid_q;
  logic [PW-1:0]      port_mem [D];
  logic [pAGE_W-1:0]  age_mem  [D];
  logic [pADDR_W:0]   count_q;

  logic               lk_valid_q, lk_hit_q, flood_q, move_q;
  logic [PW-1:0]      lk_port_q;

  logic               learn_ok, learn_hit, lookup_hit;
  logic               sw_valid, sweep_step, expire;
  logic [pAGE_W-1:0]  sw_age;

  assign tick       = (presc_q == TICK_LAST);
  assign learn_ok   = bus.i_learn_valid && ({1'b0, bus.i_learn_port} < PORT_LIM);
  assign learn_hit  = valid_q[bus.i_learn_index];
  assign lookup_hit = bus.i_lookup_valid && valid_q[bus.i_lookup_index];
  assign sw_valid   = valid_q[ptr_q];
  assign sw_age     = age_mem[ptr_q];
  // An accepted learn freezes the sweep, so learn and expiry never touch the count together.
  assign sweep_step = (state_q == SWEEP) && !learn_ok;
  assign expire     = sweep_step && sw_valid && (sw_age <= AGE_ONE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (tick || pend_q) begin
          state_d = SWEEP;
          ptr_d   = '0;
          pend_d  = 1'b0;
          if (tick && pend_q) ovr_d = 1'b1;
        end
      end
      SWEEP: begin
        if (tick) begin
          if (pend_q) ovr_d  = 1'b1;
          else        pend_d = 1'b1;
        end
        if (sweep_step) begin
          if (ptr_q == PTR_LAST) state_d = IDLE;
          else                   ptr_d   = ptr_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
      presc_q    <= '0;
      valid_q    <= '0;
      count_q    <= '0;
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_port_q  <= '0;
      flood_q    <= 1'b0;
      move_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      presc_q <= tick ? '0 : presc_q + 1'b1;

      if (learn_ok) begin
        valid_q[bus.i_learn_index] <= 1'b1;
        if (!learn_hit) count_q <= count_q + 1'b1;
      end else if (expire) begin
        valid_q[ptr_q] <= 1'b0;
        count_q        <= count_q - 1'b1;
      end

      move_q     <= learn_ok && learn_hit && (port_mem[bus.i_learn_index] != bus.i_learn_port);
      lk_valid_q <= bus.i_lookup_valid;
      lk_hit_q   <= lookup_hit;
      lk_port_q  <= lookup_hit ? port_mem[bus.i_lookup_index] : '0;
      flood_q    <= bus.i_lookup_valid && !valid_q[bus.i_lookup_index];
    end
  end

  // Port and age contents are only meaningful under a set valid bit, so they carry no reset.
  always_ff @(posedge iclk) begin
    if (learn_ok) begin
      port_mem[bus.i_learn_index] <= bus.i_learn_port;
      age_mem[bus.i_learn_index]  <= AGE_LOAD;
    end else if (sweep_step && sw_valid) begin
      age_mem[ptr_q] <= sw_age - 1'b1;
    end
  end

  assign bus.o_lookup_valid = lk_valid_q;
  assign bus.o_lookup_hit   = lk_hit_q;
  assign bus.o_lookup_port  = lk_port_q;
  assign bus.o_flood        = flood_q;
  assign bus.o_port_move    = move_q;
  assign bus.o_entry_count  = count_q;
  assign bus.o_sweep_busy   = (state_q == SWEEP);
  assign bus.o_tick_overrun = ovr_q;
endmodule

// File: tb/tb_mac_learn_age_table.sv
// Directed bench for mac_learn_age_table: a vector table for learn/lookup on a full-size
// instance, plus sequences for aging, sweep stall, tick overrun and mid-sweep reset.
module tb_mac_learn_age_table;
  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic rst_a, rst_b, rst_c;
  int   n_checks = 0;
  int   n_fail   = 0;

  mac_learn_age_table_if #(.pPORT_NUM(8), .pADDR_W(10)) ba ();
  mac_learn_age_table_if #(.pPORT_NUM(6), .pADDR_W(4))  bb ();
  mac_learn_age_table_if #(.pPORT_NUM(8), .pADDR_W(4))  bc ();

  mac_learn_age_table #(.pPORT_NUM(8), .pADDR_W(10), .pAGE_W(9), .pAGE_INIT(300), .pTICK_DIV(32768))
    dut_a (.iclk(iclk), .irst_n(rst_a), .bus(ba));
  mac_learn_age_table #(.pPORT_NUM(6), .pADDR_W(4), .pAGE_W(9), .pAGE_INIT(2), .pTICK_DIV(64))
    dut_b (.iclk(iclk), .irst_n(rst_b), .bus(bb));
  mac_learn_age_table #(.pPORT_NUM(8), .pADDR_W(4), .pAGE_W(9), .pAGE_INIT(300), .pTICK_DIV(8))
    dut_c (.iclk(iclk), .irst_n(rst_c), .bus(bc));

  typedef struct {
    logic       lv;
    logic [9:0] li;
    logic [2:0] lp;
    logic       kv;
    logic [9:0] ki;
    logic       e_lv;
    logic       e_hit;
    logic [2:0] e_port;
    logic       e_fl;
    logic       e_mv;
    logic [10:0] e_cnt;
  } vec_t;

  localparam int NA = 16;
  vec_t va [NA];

  function automatic vec_t mk(input logic lv, input logic [9:0] li, input logic [2:0] lp,
                              input logic kv, input logic [9:0] ki,
                              input logic e_lv, input logic e_hit, input logic [2:0] e_port,
                              input logic e_fl, input logic e_mv, input logic [10:0] e_cnt);
    vec_t v;
    v.lv = lv; v.li = li; v.lp = lp; v.kv = kv; v.ki = ki;
    v.e_lv = e_lv; v.e_hit = e_hit; v.e_port = e_port; v.e_fl = e_fl; v.e_mv = e_mv; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    @(negedge iclk);
  endtask

  task automatic wait_rise_b(input string tag);
    int k = 0;
    while (bb.o_sweep_busy !== 1'b1 && k < 300) begin step(); k++; end
    check({tag, " sweep start"}, 32'(bb.o_sweep_busy), 32'd1);
  endtask

  task automatic wait_fall_b(input string tag);
    int k = 0;
    while (bb.o_sweep_busy !== 1'b0 && k < 100) begin step(); k++; end
    check({tag, " sweep end"}, 32'(bb.o_sweep_busy), 32'd0);
  endtask

  task automatic learn_b(input logic [3:0] idx, input logic [2:0] port);
    bb.i_learn_valid = 1'b1; bb.i_learn_index = idx; bb.i_learn_port = port;
    step();
    bb.i_learn_valid = 1'b0;
  endtask

  task automatic lookup_b(input string tag, input logic [3:0] idx,
                          input logic e_hit, input logic [2:0] e_port);
    bb.i_lookup_valid = 1'b1; bb.i_lookup_index = idx;
    step();
    bb.i_lookup_valid = 1'b0;
    check({tag, " hit"},   32'(bb.o_lookup_hit),  32'(e_hit));
    check({tag, " port"},  32'(bb.o_lookup_port), 32'(e_port));
    check({tag, " flood"}, 32'(bb.o_flood),       32'(!e_hit));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int k;
    // learn(v,idx,port) lookup(v,idx) | expected lv hit port flood move count
    va[0]  = mk(1'b0, 10'd0,    3'd0, 1'b0, 10'd0,    1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 11'd0);
    va[1]  = mk(1'b0, 10'd0,    3'd0, 1'b1, 10'd5,    1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 11'd0);
    va[2]  = mk(1'b1, 10'd5,    3'd3, 1'b1, 10'd5,    1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 11'd1);
    va[3]  = mk(1'b0, 10'd0,    3'd0, 1'b1, 10'd5,    1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 11'd1);
    va[4]  = mk(1'b1, 10'd5,    3'd3, 1'b0, 10'd0,    1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 11'd1);
    va[5]  = mk(1'b1, 10'd5,    3'd6, 1'b0, 10'd0,    1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 11'd1);
    va[6]  = mk(1'b0, 10'd0,    3'd0, 1'b1, 10'd5,    1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 11'd1);
    va[7]  = mk(1'b1, 10'd0,    3'd0, 1'b0, 10'd0,    1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 11'd2);
    va[8]  = mk(1'b1, 10'd1023, 3'd7, 1'b0, 10'd0,    1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 11'd3);
    va[9]  = mk(1'b0, 10'd0,    3'd0, 1'b1, 10'd1023, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 11'd3);
    va[10] = mk(1'b0, 10'd0,    3'd0, 1'b1, 10'd0,    1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 11'd3);
    va[11] = mk(1'b0, 10'd0,    3'd0, 1'b1, 10'd1,    1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 11'd3);
    va[12] = mk(1'b1, 10'd1023, 3'd2, 1'b1, 10'd1023, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 11'd3);
    va[13] = mk(1'b0, 10'd0,    3'd0, 1'b1, 10'd1023, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 11'd3);
    va[14] = mk(1'b1, 10'd1,    3'd5, 1'b1, 10'd0,    1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 11'd4);
    va[15] = mk(1'b0, 10'd0,    3'd0, 1'b0, 10'd0,    1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 11'd4);

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ba.i_learn_valid = 1'b0; ba.i_learn_index = '0; ba.i_learn_port = '0;
    ba.i_lookup_valid = 1'b0; ba.i_lookup_index = '0;
    bb.i_learn_valid = 1'b0; bb.i_learn_index = '0; bb.i_learn_port = '0;
    bb.i_lookup_valid = 1'b0; bb.i_lookup_index = '0;
    bc.i_learn_valid = 1'b0; bc.i_learn_index = '0; bc.i_learn_port = '0;
    bc.i_lookup_valid = 1'b0; bc.i_lookup_index = '0;
    step(); step();

    // Table-driven learn/lookup on the full-size instance
    rst_a = 1'b1;
    for (int i = 0; i < NA; i++) begin
      ba.i_learn_valid  = va[i].lv;
      ba.i_learn_index  = va[i].li;
      ba.i_learn_port   = va[i].lp;
      ba.i_lookup_valid = va[i].kv;
      ba.i_lookup_index = va[i].ki;
      step();
      check($sformatf("A%0d lookup_valid", i), 32'(ba.o_lookup_valid), 32'(va[i].e_lv));
      check($sformatf("A%0d hit", i),          32'(ba.o_lookup_hit),   32'(va[i].e_hit));
      check($sformatf("A%0d port", i),         32'(ba.o_lookup_port),  32'(va[i].e_port));
      check($sformatf("A%0d flood", i),        32'(ba.o_flood),        32'(va[i].e_fl));
      check($sformatf("A%0d port_move", i),    32'(ba.o_port_move),    32'(va[i].e_mv));
      check($sformatf("A%0d entry_count", i),  32'(ba.o_entry_count),  32'(va[i].e_cnt));
    end
    check("A sweep_busy", 32'(ba.o_sweep_busy), 32'd0);
    check("A tick_overrun", 32'(ba.o_tick_overrun), 32'd0);
    ba.i_learn_valid = 1'b0; ba.i_lookup_valid = 1'b0;

    // Aging: AGE_INIT=2, 64-cycle tick, 16 entries, ports 6/7 out of range
    rst_b = 1'b1;
    learn_b(4'd2, 3'd1);
    learn_b(4'd3, 3'd4);
    learn_b(4'd11, 3'd6);
    learn_b(4'd12, 3'd7);
    check("B count after learns", 32'(bb.o_entry_count), 32'd2);
    lookup_b("B ignored port", 4'd11, 1'b0, 3'd0);
    wait_rise_b("B1"); wait_fall_b("B1");
    check("B count after sweep1", 32'(bb.o_entry_count), 32'd2);
    learn_b(4'd3, 3'd4);
    check("B relearn no move", 32'(bb.o_port_move), 32'd0);
    wait_rise_b("B2"); wait_fall_b("B2");
    check("B count after sweep2", 32'(bb.o_entry_count), 32'd1);
    lookup_b("B expired idx2", 4'd2, 1'b0, 3'd0);
    lookup_b("B refreshed idx3", 4'd3, 1'b1, 3'd4);
    learn_b(4'd3, 3'd4);
    wait_rise_b("B3"); wait_fall_b("B3");
    check("B count after sweep3", 32'(bb.o_entry_count), 32'd1);

    // Learn held for 20 cycles inside a sweep stretches it from 16 to 36 cycles
    learn_b(4'd3, 3'd4);
    learn_b(4'd7, 3'd2);
    check("B count before stall", 32'(bb.o_entry_count), 32'd2);
    wait_rise_b("B stall");
    bb.i_learn_valid = 1'b1; bb.i_learn_index = 4'd7; bb.i_learn_port = 3'd2;
    busy_n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bb.o_sweep_busy === 1'b1) busy_n++;
    end
    bb.i_learn_valid = 1'b0;
    k = 0;
    while (bb.o_sweep_busy === 1'b1 && k < 100) begin
      step(); k++;
      if (bb.o_sweep_busy === 1'b1) busy_n++;
    end
    check("B stall length", 32'(busy_n), 32'd36);
    check("B count after stall", 32'(bb.o_entry_count), 32'd2);
    learn_b(4'd3, 3'd5);
    check("B port move", 32'(bb.o_port_move), 32'd1);
    check("B count on move", 32'(bb.o_entry_count), 32'd2);
    lookup_b("B moved idx3", 4'd3, 1'b1, 3'd5);
    lookup_b("B stalled idx7", 4'd7, 1'b1, 3'd2);

    // Overrun: 8-cycle tick against a 16-cycle sweep
    rst_c = 1'b1;
    bc.i_learn_valid = 1'b1; bc.i_learn_index = 4'd4; bc.i_learn_port = 3'd1;
    step();
    bc.i_learn_valid = 1'b0;
    check("C count after learn", 32'(bc.o_entry_count), 32'd1);
    k = 0;
    while (bc.o_sweep_busy !== 1'b1 && k < 50) begin step(); k++; end
    check("C first sweep", 32'(bc.o_sweep_busy), 32'd1);
    repeat (10) step();
    check("C pending absorbs", 32'(bc.o_tick_overrun), 32'd0);
    check("C still sweeping", 32'(bc.o_sweep_busy), 32'd1);
    repeat (6) step();
    check("C idle gap", 32'(bc.o_sweep_busy), 32'd0);
    check("C overrun set", 32'(bc.o_tick_overrun), 32'd1);
    step();
    check("C pending restart", 32'(bc.o_sweep_busy), 32'd1);
    repeat (3) step();
    check("C count pre reset", 32'(bc.o_entry_count), 32'd1);
    rst_c = 1'b0;
    #1;
    check("C reset busy", 32'(bc.o_sweep_busy), 32'd0);
    check("C reset count", 32'(bc.o_entry_count), 32'd0);
    check("C reset overrun", 32'(bc.o_tick_overrun), 32'd0);
    @(negedge iclk);
    rst_c = 1'b1;
    bc.i_lookup_valid = 1'b1; bc.i_lookup_index = 4'd4;
    step();
    bc.i_lookup_valid = 1'b0;
    check("C post reset hit", 32'(bc.o_lookup_hit), 32'd0);
    check("C post reset flood", 32'(bc.o_flood), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_learn_age_table.md
Name: mac_learn_age_table

Overview:
Parametrised MAC forwarding table with per-entry valid bit, per-entry age counter, and a background aging sweep.
- Learn path writes a source-index-to-port binding; lookup path returns the egress port, or a flood indication on miss.
- Sits between the frame parser (index source) and the switch fabric arbiter (port consumer).
- Adds to the first-generation table: valid tracking, hit/miss, bounded-rate sweep FSM, entry accounting, and port-move detection.

Parameters:
pPORT_NUM, 8, number of switch ports; port field width PW = $clog2(pPORT_NUM).
pADDR_W, 10, table index width; depth D = 2**pADDR_W.
pAGE_W, 9, age counter width.
pAGE_INIT, 300, age loaded on learn (must be 1..2**pAGE_W-1).
pTICK_DIV, 32768, clock cycles per age tick.

Ports:
iclk  in  1  clock, all logic on rising edge.
irst_n  in  1  asynchronous active-low reset.
i_learn_valid  in  1  learn request, single-cycle qualifier.
i_learn_index  in  pADDR_W  table index of source MAC.
i_learn_port  in  PW  ingress port of source MAC.
i_lookup_valid  in  1  lookup request.
i_lookup_index  in  pADDR_W  table index of destination MAC.
o_lookup_valid  out  1  lookup result strobe.
o_lookup_hit  out  1  entry valid at lookup.
o_lookup_port  out  PW  stored port; 0 on miss.
o_flood  out  1  equals o_lookup_valid & ~o_lookup_hit.
o_port_move  out  1  pulse: learn hit a valid entry with a different port.
o_entry_count  out  pADDR_W+1  number of valid entries.
o_sweep_busy  out  1  high while sweep FSM not IDLE.
o_tick_overrun  out  1  sticky: tick arrived with one already pending.

Behaviour:
- Reset (async assert, sync use after deassert): all valid bits 0, prescaler 0, FSM IDLE, sweep pointer 0, pending 0. All outputs 0. Port/age storage contents are don't-care because valid bits gate them.
- Prescaler: counts 0..pTICK_DIV-1 and wraps. Tick is a 1-cycle pulse at the terminal count.
- Learn (cycle N):
  - Ignored if i_learn_port >= pPORT_NUM.
  - Otherwise sets valid=1, port=i_learn_port, age=pAGE_INIT at entry i_learn_index.
  - Invalid target: o_entry_count +1 at N+1.
  - Valid target with different port: o_port_move=1 at N+1; count unchanged.
- Lookup (cycle N): o_lookup_valid/hit/port/o_flood registered at N+1, reflecting contents before any same-cycle learn (read-first). Back-to-back lookups are accepted every cycle.
- Sweep FSM, states IDLE, SWEEP:
  - IDLE -> SWEEP on tick or pending; clears pending; pointer=0.
  - SWEEP: one entry per cycle at the pointer.
    - Valid entry with age>1: age decrements.
    - Valid entry with age==1: age becomes 0, valid cleared, o_entry_count -1.
    - Invalid entry: untouched.
    - Pointer increments.
  - After index D-1 is processed: -> IDLE.
  - Learn has priority: any cycle with an accepted learn stalls the sweep (pointer holds, no decrement). Learn and age-removal therefore never coincide, and count is never +1 and -1 in the same cycle.
  - Tick while SWEEP: pending set. Tick while pending already set: tick lost, o_tick_overrun set (cleared only by reset).
- Count arithmetic: never exceeds D, never underflows. Width pADDR_W+1 holds D.
- Reset mid-sweep: FSM to IDLE, all entries invalid, count 0; no partial state survives.
- Learning the sweep pointer's index: the entry is refreshed to pAGE_INIT, and the sweep then decrements it when it resumes.

Test Plan:
- Reset, then lookup index 5 -> o_lookup_valid=1, hit=0, port=0, o_flood=1 one cycle later; o_entry_count=0.
- Learn idx 5 port 3, then lookup idx 5 next cycle -> hit=1, port=3, flood=0, count=1. Same-cycle learn+lookup idx 5 from empty -> miss (read-first).
- Learn idx 5 port 3, then idx 5 port 6 -> o_port_move pulse on second only; count stays 1; lookup returns 6. Learn with port 8 (pPORT_NUM=8) -> ignored, no count change.
- pAGE_INIT=2, pTICK_DIV=64, pADDR_W=4: learn idx 2 -> after 2 completed sweeps entry invalid, count 0, lookup floods. Relearn between sweeps -> never expires.
- Hold i_learn_valid high for 20 cycles during a sweep -> sweep duration extended by exactly 20 cycles; all entries still decremented exactly once.
- pTICK_DIV=8 with D=16 -> pending absorbs first overlap; second overlap sets o_tick_overrun=1. Assert irst_n=0 mid-sweep -> o_sweep_busy=0, count=0 immediately.
